// File: rtl/fpadd_expcomp.sv
// fpadd_expcomp: exponent-compare front stage of the binary32 adder, 2-stage pipeline with backpressure
module fpadd_expcomp #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alessb,
    output logic [23:0]      manta,
    output logic [23:0]      mantb,
    output logic [7:0]       shamt,
    output logic [7:0]       exp_pre,
    output logic [CNT_W-1:0] done_cnt
);
    logic [31:0] s1_a, s1_b;
    logic        s1_v, s1_load, s2_load, lt;
    logic [7:0]  ea, eb;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;
    assign ea       = s1_a[30:23];
    assign eb       = s1_b[30:23];
    assign lt       = ea < eb;

    // stage 1: capture the raw operand pair whenever the stage can advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            s1_a <= a;
            s1_b <= b;
        end
    end

    // stage 2: register the exponent comparison and unpacked mantissas
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            alessb    <= 1'b0;
            shamt     <= '0;
            exp_pre   <= '0;
            manta     <= '0;
            mantb     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_v;
            alessb    <= lt;
            shamt     <= lt ? eb - ea : ea - eb;
            exp_pre   <= lt ? eb : ea;
            manta     <= {1'b1, s1_a[22:0]};
            mantb     <= {1'b1, s1_b[22:0]};
        end
    end

    // count bundles consumed downstream, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            done_cnt <= '0;
        else if (out_valid && out_ready)
            done_cnt <= done_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fpadd_expcomp.sv
// tb_fpadd_expcomp: scoreboard bench for the exponent-compare stage
module tb_fpadd_expcomp;
    logic        clk = 0, reset = 0, in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, alessb;
    logic [23:0] manta, mantb;
    logic [7:0]  shamt, exp_pre;
    logic [3:0]  done_cnt;

    fpadd_expcomp #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .alessb(alessb), .manta(manta), .mantb(mantb), .shamt(shamt),
        .exp_pre(exp_pre), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        al;
        logic [23:0] ma;
        logic [23:0] mb;
        logic [7:0]  sh;
        logic [7:0]  ep;
    } want_t;

    want_t       sbq[$];
    want_t       ve[9];
    logic [31:0] va[9], vb[9];
    int          checks = 0, errors = 0, cur = 0, nxt = 0;
    logic        took = 0, ov_seen = 0, ir_seen = 0, hold_pending = 0;
    want_t       got, held, popped;

    function automatic want_t mk(logic al, logic [7:0] sh, logic [7:0] ep, logic [23:0] ma, logic [23:0] mb);
        return {al, ma, mb, sh, ep};
    endfunction

    task automatic check(string name, logic [64:0] act, logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: pop and compare on every output transfer, and check stall stability
    always @(negedge clk) begin
        got = {alessb, manta, mantb, shamt, exp_pre};
        if (reset) begin
            if (hold_pending) check("stall_hold", got, held);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bundle: got %h expected none at %0t", got, $time);
                end else begin
                    popped = sbq.pop_front();
                    check("bundle", got, popped);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = got;
        end else
            hold_pending = 0;
    end

    task automatic drive(int i);
        a = va[i];
        b = vb[i];
        cur = i;
        in_valid = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        took = in_valid && in_ready;
        ov_seen = out_valid;
        ir_seen = in_ready;
        if (took) sbq.push_back(ve[cur]);
        @(posedge clk);
        #1;
    endtask

    task automatic send(int i);
        drive(i);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (took) begin
                in_valid = 0;
                return;
            end
        end
        in_valid = 0;
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept of vector %0d", i);
    endtask

    task automatic drain();
        in_valid = 0;
        for (int k = 0; k < 50; k++) begin
            if (sbq.size() == 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        va[0] = 32'h40400000; vb[0] = 32'h3F800000; ve[0] = mk(0, 8'h01, 8'h80, 24'hC00000, 24'h800000);
        va[1] = 32'h3F800000; vb[1] = 32'h40400000; ve[1] = mk(1, 8'h01, 8'h80, 24'h800000, 24'hC00000);
        va[2] = 32'h3FC00000; vb[2] = 32'h3FC00000; ve[2] = mk(0, 8'h00, 8'h7F, 24'hC00000, 24'hC00000);
        va[3] = 32'h00800000; vb[3] = 32'h7F000000; ve[3] = mk(1, 8'hFD, 8'hFE, 24'h800000, 24'h800000);
        va[4] = 32'h41200000; vb[4] = 32'h40000000; ve[4] = mk(0, 8'h02, 8'h82, 24'hA00000, 24'h800000);
        va[5] = 32'h3E800000; vb[5] = 32'h42C80000; ve[5] = mk(1, 8'h08, 8'h85, 24'h800000, 24'hC80000);
        va[6] = 32'h7F7FFFFF; vb[6] = 32'h00800000; ve[6] = mk(0, 8'hFD, 8'hFE, 24'hFFFFFF, 24'h800000);
        va[7] = 32'h3F000001; vb[7] = 32'h3F7FFFFF; ve[7] = mk(0, 8'h00, 8'h7E, 24'h800001, 24'hFFFFFF);
        va[8] = 32'hC0400000; vb[8] = 32'hBF800000; ve[8] = mk(0, 8'h01, 8'h80, 24'hC00000, 24'h800000);

        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_done_cnt", done_cnt, 0);
        check("reset_bundle", {alessb, manta, mantb, shamt, exp_pre}, 0);
        @(posedge clk); #3 reset = 1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        out_ready = 1;
        send(0);
        @(negedge clk);
        check("latency_edge_n", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_edge_n1", out_valid, 1);
        @(posedge clk); #1;
        send(1);
        send(2);
        send(3);
        send(8);
        drain();
        check("done_cnt_basic", done_cnt, 5);

        out_ready = 0;
        nxt = 4;
        for (int c = 0; c < 3; c++) begin
            if (nxt < 8) drive(nxt); else in_valid = 0;
            tick();
            if (took) nxt++;
        end
        check("bp_accepted", nxt - 4, 2);
        check("bp_in_ready_low", ir_seen, 0);
        out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (nxt < 8) drive(nxt); else in_valid = 0;
            tick();
            check("bp_one_per_cycle", ov_seen, 1);
            if (took) nxt++;
        end
        check("bp_all_accepted", nxt, 8);
        drain();
        check("done_cnt_bp", done_cnt, 9);

        out_ready = 0;
        send(0);
        send(1);
        #2 reset = 0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_done_cnt", done_cnt, 0);
        sbq.delete();
        @(posedge clk); #3 reset = 1;
        @(negedge clk);
        check("postreset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1;
        repeat (3) tick();
        check("postreset_no_stale", ov_seen, 0);

        for (int k = 0; k < 17; k++) send(k % 9);
        drain();
        check("done_cnt_wrap", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
